// File: rtl/mvm_frame_arbiter_if.sv
// ============================================================================
// mvm_frame_arbiter_if : streams and status between two requesters, the
// frame arbiter and a shared MVM engine.   Rev 1.0
// ============================================================================
`default_nettype none

interface mvm_frame_arbiter_if #(
  parameter int W = 8
);
  logic         s0_valid, s0_ready;
  logic [W-1:0] s0_data;
  logic         s1_valid, s1_ready;
  logic [W-1:0] s1_data;
  logic         m0_valid, m0_ready;
  logic [W-1:0] m0_data;
  logic         m1_valid, m1_ready;
  logic [W-1:0] m1_data;
  logic         eng_s_valid, eng_s_ready;
  logic [W-1:0] eng_data_in;
  logic         eng_m_valid, eng_m_ready;
  logic [W-1:0] eng_data_out;
  logic         owner;
  logic         busy;
  logic [15:0]  frames0, frames1;

  // Arbiter side
  modport master (
    input  s0_valid, s0_data, s1_valid, s1_data,
    output s0_ready, s1_ready,
    output m0_valid, m0_data, m1_valid, m1_data,
    input  m0_ready, m1_ready,
    output eng_s_valid, eng_data_in, eng_m_ready,
    input  eng_s_ready, eng_m_valid, eng_data_out,
    output owner, busy, frames0, frames1
  );

  // Requester / engine / observer side
  modport slave (
    output s0_valid, s0_data, s1_valid, s1_data,
    input  s0_ready, s1_ready,
    input  m0_valid, m0_data, m1_valid, m1_data,
    output m0_ready, m1_ready,
    input  eng_s_valid, eng_data_in, eng_m_ready,
    output eng_s_ready, eng_m_valid, eng_data_out,
    input  owner, busy, frames0, frames1
  );
endinterface

`default_nettype wire

// File: rtl/mvm_frame_arbiter.sv
// ============================================================================
// mvm_frame_arbiter : round-robin frame arbiter sharing one MVM engine
// between two requesters (N input beats, then M result beats).   Rev 1.0
// ============================================================================
`default_nettype none

module mvm_frame_arbiter #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  mvm_frame_arbiter_if.master    bus
);

  localparam int IW = $clog2(N + 1);
  localparam int OW = $clog2(M + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state, w_next_state;
  logic [IW-1:0] r_in_cnt;
  logic [OW-1:0] r_out_cnt;
  logic          r_owner, r_last_grant;
  logic [15:0]   r_frames0, r_frames1;

  logic w_any_req, w_grant;
  logic w_sel_s_valid, w_sel_m_ready;
  logic w_in_fire, w_out_fire, w_in_last, w_out_last;

  assign w_any_req     = bus.s0_valid | bus.s1_valid;
  // On a tie the requester that did not own the previous frame wins
  assign w_grant       = (bus.s0_valid & bus.s1_valid) ? ~r_last_grant : bus.s1_valid;
  assign w_sel_s_valid = r_owner ? bus.s1_valid : bus.s0_valid;
  assign w_sel_m_ready = r_owner ? bus.m1_ready : bus.m0_ready;
  assign w_in_fire     = (r_state == S_FEED)  & w_sel_s_valid & bus.eng_s_ready;
  assign w_out_fire    = (r_state == S_DRAIN) & bus.eng_m_valid & w_sel_m_ready;
  assign w_in_last     = (r_in_cnt  == IW'(N - 1));
  assign w_out_last    = (r_out_cnt == OW'(M - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)               w_next_state = S_FEED;
      S_FEED:  if (w_in_fire && w_in_last)   w_next_state = S_DRAIN;
      S_DRAIN: if (w_out_fire && w_out_last) w_next_state = S_IDLE;
      default:                               w_next_state = S_IDLE;
    endcase
  end

  // Output decode; reset forces every handshake output low
  always_comb begin
    bus.s0_ready    = 1'b0;
    bus.s1_ready    = 1'b0;
    bus.m0_valid    = 1'b0;
    bus.m1_valid    = 1'b0;
    bus.m0_data     = {W{1'b0}};
    bus.m1_data     = {W{1'b0}};
    bus.eng_s_valid = 1'b0;
    bus.eng_data_in = {W{1'b0}};
    bus.eng_m_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FEED: begin
          bus.eng_s_valid = w_sel_s_valid;
          bus.eng_data_in = r_owner ? bus.s1_data : bus.s0_data;
          if (r_owner) bus.s1_ready = bus.eng_s_ready;
          else         bus.s0_ready = bus.eng_s_ready;
        end
        S_DRAIN: begin
          bus.eng_m_ready = w_sel_m_ready;
          if (r_owner) begin
            bus.m1_valid = bus.eng_m_valid;
            bus.m1_data  = bus.eng_data_out;
          end else begin
            bus.m0_valid = bus.eng_m_valid;
            bus.m0_data  = bus.eng_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_frames0    <= 16'd0;
      r_frames1    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_req) r_owner <= w_grant;
        S_FEED: if (w_in_fire) r_in_cnt <= w_in_last ? '0 : r_in_cnt + IW'(1);
        S_DRAIN: begin
          if (w_out_fire) begin
            if (w_out_last) begin
              r_out_cnt    <= '0;
              r_last_grant <= r_owner;
              if (r_owner) r_frames1 <= r_frames1 + 16'd1;
              else         r_frames0 <= r_frames0 + 16'd1;
            end else begin
              r_out_cnt <= r_out_cnt + OW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.owner   = r_owner;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.frames0 = r_frames0;
  assign bus.frames1 = r_frames1;

endmodule

`default_nettype wire

// File: doc/mvm_frame_arbiter.md
MVM_FRAME_ARBITER -- requirements
Module: mvm_frame_arbiter

Interface
REQ-001 Parameter N, default 8, input-vector beats per frame (N >= 1).
REQ-002 Parameter M, default 8, result beats per frame (M >= 1).
REQ-003 Parameter W, default 8, signed data width.
REQ-004 The block SHALL use clock clk; reset reset, synchronous, active-high.
REQ-005 Port list; all vectors are W bits wide unless noted; all ports are 1 bit otherwise:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s0_valid/s0_ready/s0_data  in/out/in  1/1/W  requester-0 input stream
- s1_valid/s1_ready/s1_data  in/out/in  1/1/W  requester-1 input stream
- m0_valid/m0_ready/m0_data  out/in/out  1/1/W  requester-0 result stream
- m1_valid/m1_ready/m1_data  out/in/out  1/1/W  requester-1 result stream
- eng_s_valid/eng_s_ready/eng_data_in  out/in/out  1/1/W  shared MVM engine input
- eng_m_valid/eng_m_ready/eng_data_out  in/out/in  1/1/W  shared MVM engine output
- owner  out  1  current grant index
- busy  out  1  high in FEED or DRAIN
- frames0/frames1  out  16/16  completed-frame counters per requester

Function
REQ-006 FSM states: IDLE, FEED, DRAIN; all state, counters and grant registered.
REQ-007 IDLE: if exactly one of s0_valid/s1_valid is high, grant that requester; if both are high, grant the requester != last_grant (round-robin); move to FEED next cycle.
REQ-008 No beat is transferred in the IDLE cycle; all s*_ready = 0 in IDLE.
REQ-009 FEED: eng_s_valid = sG_valid, sG_ready = eng_s_ready, eng_data_in = sG_data (combinational, zero added latency); the non-granted s*_ready = 0.
REQ-010 in_cnt counts accepted beats (eng_s_valid & eng_s_ready); on the Nth accepted beat, clear in_cnt and go to DRAIN.
REQ-011 eng_m_ready = 0 in IDLE and FEED; engine output is never consumed outside DRAIN.
REQ-012 DRAIN: mG_valid = eng_m_valid, eng_m_ready = mG_ready, mG_data = eng_data_out; the non-granted m*_valid = 0; eng_s_valid = 0.
REQ-013 out_cnt counts result handshakes; on the Mth, clear out_cnt, set last_grant = owner, increment framesG (wraps at 2^16), return to IDLE.
REQ-014 A new frame may be granted in the cycle after DRAIN exits (IDLE dwell is exactly 1 cycle).
REQ-015 All m*_data and eng_data_in SHALL be 0 whenever the matching valid is forced 0.
REQ-016 Requester valid may deassert mid-frame; the frame stalls in FEED with counts held; no timeout.
REQ-017 owner holds its value from grant through IDLE until the next grant.
REQ-018 busy = (state != IDLE).
REQ-019 Counter widths: in_cnt is clog2(N+1) bits, out_cnt is clog2(M+1) bits; no overflow past N/M.

Reset
REQ-020 On reset: state = IDLE, in_cnt = out_cnt = 0, owner = 0, last_grant = 1 (requester 0 wins first tie), frames0 = frames1 = 0.
REQ-021 While reset is high, all ready/valid outputs SHALL be 0, overriding the state decode.
REQ-022 A reset asserted mid-FEED or mid-DRAIN aborts the frame; no framesG increment; the partial frame is discarded.

Verification
REQ-023 Single requester: s0 sends 8 beats 1..8, engine returns 8 results 10..17 -> m0 sees 10..17, m1_valid never high, frames0 = 1, owner = 0.
REQ-024 Tie after reset: s0_valid = s1_valid = 1 constantly -> grants alternate 0,1,0,1 across 4 frames; frames0 = frames1 = 2.
REQ-025 Backpressure: eng_s_ready toggled 1,0 and m0_ready held 0 for 5 cycles in DRAIN -> no beat lost or duplicated; in_cnt/out_cnt hold during stalls.
REQ-026 Isolation: s1 asserts valid with data 0x55 during owner-0 FEED -> s1_ready = 0, eng_data_in never 0x55, s1 granted at the next IDLE.
REQ-027 Reset after 3 of 8 FEED beats -> IDLE next cycle, frames0 = 0, busy = 0; a fresh full frame then completes normally.
REQ-028 Early engine output: eng_m_valid = 1 during FEED -> eng_m_ready = 0 and m*_valid = 0 until DRAIN.
